accuracy_monitor: RTL and testbench

- Hardware scoreboard on the classifier output interface: consumes the network's `result` / `batch_done` handshake and fetches the expected label for each sample from a synchronous label ROM.
- Counts total and correct classifications, then computes integer accuracy percentage once the test set completes.
- Sits beside the classifier top on FPGA; replaces the software label comparison so accuracy is observable on hardware.

---
 rtl/accuracy_monitor_pkg.sv | 15 +
 rtl/pct_divider.sv | 36 +++
 rtl/accuracy_monitor.sv | 105 ++++++++++
 tb/tb_accuracy_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/accuracy_monitor_pkg.sv
// accuracy_monitor_pkg: shared defaults and state encoding for the accuracy monitor
package accuracy_monitor_pkg;
  localparam int DEF_NUM_SAMPLES = 750;
  localparam int DEF_LABEL_W = 8;
  localparam int DEF_RESULT_W = 4;
  localparam int DEF_CNT_W = 10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_FETCH,
    S_COMPARE,
    S_DIVIDE,
    S_DONE
  } state_t;
endpackage

// File: rtl/pct_divider.sv
// pct_divider: iterative restoring-free divider, one subtraction of the divisor per cycle
module pct_divider #(
  parameter int W = 17,
  parameter int QW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          abort,
  input  logic          load,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic [QW-1:0] quotient,
  output logic          busy,
  output logic          done
);
  logic [W-1:0] acc;
  // done is combinational so the caller can leave in the very cycle the remainder drops below the divisor
  always_comb done = busy && (acc < divisor);
  // load the dividend, then peel off one divisor per cycle until the remainder is small enough
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      acc <= '0;
      quotient <= '0;
      busy <= 1'b0;
    end else if (load) begin
      acc <= dividend;
      quotient <= '0;
      busy <= 1'b1;
    end else if (done) begin
      busy <= 1'b0;
    end else if (busy) begin
      acc <= acc - divisor;
      quotient <= quotient + QW'(1);
    end
  end
endmodule

// File: rtl/accuracy_monitor.sv
// accuracy_monitor: scores classifier results against a label ROM and reports integer accuracy
module accuracy_monitor
  import accuracy_monitor_pkg::*;
#(
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
  parameter int LABEL_W = DEF_LABEL_W,
  parameter int RESULT_W = DEF_RESULT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RESULT_W-1:0] result,
  input  logic               batch_done,
  output logic               label_rd_en,
  output logic [CNT_W-1:0]   label_addr,
  input  logic [LABEL_W-1:0] label_data,
  output logic               busy,
  output logic [CNT_W-1:0]   total_count,
  output logic [CNT_W-1:0]   correct_count,
  output logic               mismatch,
  output logic               overrun,
  output logic [6:0]         accuracy_pct,
  output logic               all_done
);
  localparam int DW = CNT_W + 7;
  state_t state;
  logic [RESULT_W-1:0] res_q;
  logic hit, last, div_load, div_busy, div_done;
  logic [DW-1:0] dividend;
  logic [6:0] quotient;
  // compare outcome, end-of-run detection and the divider operand for the final sample
  always_comb begin
    hit = LABEL_W'(res_q) == label_data;
    last = total_count == CNT_W'(NUM_SAMPLES - 1);
    div_load = !start && state == S_COMPARE && last;
    dividend = (DW'(correct_count) + DW'(hit)) * DW'(100);
  end
  pct_divider #(.W(DW), .QW(7)) u_div (
    .clk(clk),
    .rst(rst),
    .abort(start),
    .load(div_load),
    .dividend(dividend),
    .divisor(DW'(NUM_SAMPLES)),
    .quotient(quotient),
    .busy(div_busy),
    .done(div_done)
  );
  // run control: wait for a sample, fetch its label, score it, and divide once the set completes
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      res_q <= '0;
      label_rd_en <= 1'b0;
      label_addr <= '0;
      busy <= 1'b0;
      total_count <= '0;
      correct_count <= '0;
      mismatch <= 1'b0;
      overrun <= 1'b0;
      accuracy_pct <= '0;
      all_done <= 1'b0;
    end else begin
      label_rd_en <= 1'b0;
      mismatch <= 1'b0;
      if (start) begin
        state <= S_WAIT;
        busy <= 1'b1;
        all_done <= 1'b0;
        total_count <= '0;
        correct_count <= '0;
        overrun <= 1'b0;
        accuracy_pct <= '0;
      end else begin
        case (state)
          S_WAIT: if (batch_done) begin
            res_q <= result;
            label_rd_en <= 1'b1;
            label_addr <= total_count;
            state <= S_FETCH;
          end
          S_FETCH: begin
            overrun <= overrun | batch_done;
            state <= S_COMPARE;
          end
          S_COMPARE: begin
            overrun <= overrun | batch_done;
            correct_count <= hit ? correct_count + CNT_W'(1) : correct_count;
            mismatch <= !hit;
            total_count <= total_count + CNT_W'(1);
            state <= last ? S_DIVIDE : S_WAIT;
          end
          S_DIVIDE: if (div_done) begin
            accuracy_pct <= quotient;
            all_done <= 1'b1;
            busy <= 1'b0;
            state <= S_DONE;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_accuracy_monitor.sv
// tb_accuracy_monitor: directed and randomized checks of accuracy_monitor against a sample-level model
module tb_accuracy_monitor;
  localparam int N = 750;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [3:0] result = '0;
  logic batch_done = 1'b0;
  logic label_rd_en;
  logic [9:0] label_addr;
  logic [7:0] label_data = '0;
  logic busy;
  logic [9:0] total_count;
  logic [9:0] correct_count;
  logic mismatch;
  logic overrun;
  logic [6:0] accuracy_pct;
  logic all_done;
  logic [7:0] rom [1024];
  int n_assert = 0;
  int n_fail = 0;
  int mm_cnt = 0;
  int mm_tot = 0;
  int rd_cnt = 0;
  int m_total = 0;
  int m_correct = 0;

  accuracy_monitor dut (
    .clk(clk), .rst(rst), .start(start), .result(result), .batch_done(batch_done),
    .label_rd_en(label_rd_en), .label_addr(label_addr), .label_data(label_data),
    .busy(busy), .total_count(total_count), .correct_count(correct_count),
    .mismatch(mismatch), .overrun(overrun), .accuracy_pct(accuracy_pct), .all_done(all_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (label_rd_en) label_data <= rom[label_addr];

  always @(negedge clk) begin
    if (mismatch) begin
      mm_cnt++;
      mm_tot = int'(total_count);
    end
    if (label_rd_en) rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    m_total = 0;
    m_correct = 0;
  endtask

  task automatic send(input logic [3:0] r, input int gap);
    @(negedge clk);
    result = r;
    batch_done = 1'b1;
    if (m_total < N) begin
      m_correct += (int'(r) == int'(rom[m_total])) ? 1 : 0;
      m_total++;
    end
    @(negedge clk) batch_done = 1'b0;
    tick(gap - 1);
  endtask

  task automatic fill_rom();
    for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 9));
  endtask

  task automatic feed(input int ncorr, input int upto);
    int need;
    logic [3:0] r;
    need = ncorr;
    for (int i = 0; i < upto; i++) begin
      if (need > 0 && int'($urandom_range(0, N - i - 1)) < need) begin
        r = rom[i][3:0];
        need--;
      end else r = 4'((int'(rom[i]) + int'($urandom_range(1, 9))) % 10);
      send(r, (i == upto - 1) ? 3 : int'($urandom_range(3, 5)));
    end
  endtask

  task automatic wait_done(input int lim);
    int c;
    c = 0;
    while (!all_done && c < lim) begin
      tick(1);
      c++;
    end
    chk("all_done_within_bound", all_done, 1);
  endtask

  initial begin
    int rd0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_total", total_count, 0);
    chk("rst_correct", correct_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_pct", accuracy_pct, 0);
    chk("rst_rd_en", label_rd_en, 0);
    chk("rst_mismatch", mismatch, 0);
    rst = 1'b0;
    tick(2);

    rom[0] = 8'd7; rom[1] = 8'd2; rom[2] = 8'd1;
    pulse_start();
    chk("start_busy", busy, 1);
    @(negedge clk);
    result = 4'd7;
    batch_done = 1'b1;
    m_total = 1; m_correct = 1;
    @(negedge clk) batch_done = 1'b0;
    chk("n1_rd_en", label_rd_en, 1);
    chk("n1_addr", label_addr, 0);
    chk("n1_total", total_count, 0);
    tick(1);
    chk("n2_rd_en", label_rd_en, 0);
    chk("n2_total", total_count, 0);
    tick(1);
    chk("n3_total", total_count, 1);
    chk("n3_correct", correct_count, 1);
    tick(2);
    send(4'd3, 5);
    send(4'd1, 5);
    chk("t1_total", total_count, 3);
    chk("t1_correct", correct_count, m_correct);
    chk("t1_mismatch_pulses", mm_cnt, 1);
    chk("t1_mismatch_on_second", mm_tot, 2);
    chk("t1_overrun", overrun, 0);
    chk("t1_rd_pulses", rd_cnt, 3);

    pulse_start();
    chk("ovr_cleared_total", total_count, 0);
    @(negedge clk);
    result = 4'd7;
    batch_done = 1'b1;
    @(negedge clk) batch_done = 1'b0;
    @(negedge clk) batch_done = 1'b1;
    @(negedge clk) batch_done = 1'b0;
    m_total = 1; m_correct = 1;
    tick(3);
    chk("ovr_flag", overrun, 1);
    chk("ovr_total", total_count, 1);
    send(4'd2, 4);
    chk("ovr_total_after", total_count, 2);
    chk("ovr_correct_after", correct_count, m_correct);
    chk("ovr_sticky", overrun, 1);

    fill_rom();
    pulse_start();
    chk("run80_overrun_clear", overrun, 0);
    feed(600, N);
    wait_done(110);
    chk("run80_pct", accuracy_pct, m_correct * 100 / N);
    chk("run80_pct_const", accuracy_pct, 80);
    chk("run80_busy", busy, 0);
    chk("run80_total", total_count, N);
    chk("run80_correct", correct_count, m_correct);
    rd0 = rd_cnt;
    send(4'd1, 3);
    send(4'd2, 3);
    chk("done_total_hold", total_count, 750);
    chk("done_correct_hold", correct_count, 600);
    chk("done_no_overrun", overrun, 0);
    chk("done_no_rd", rd_cnt, rd0);
    chk("done_level", all_done, 1);

    fill_rom();
    pulse_start();
    chk("restart_clears_done", all_done, 0);
    feed(N, N);
    wait_done(110);
    chk("run100_pct", accuracy_pct, 100);
    chk("run100_correct", correct_count, N);

    fill_rom();
    pulse_start();
    feed(0, N);
    tick(1);
    chk("run0_done_fast", all_done, 1);
    chk("run0_pct", accuracy_pct, 0);
    chk("run0_busy", busy, 0);

    fill_rom();
    pulse_start();
    feed(3, 5);
    @(negedge clk);
    result = rom[5][3:0];
    batch_done = 1'b1;
    @(negedge clk) batch_done = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    m_total = 0; m_correct = 0;
    chk("abort_total", total_count, 0);
    chk("abort_correct", correct_count, 0);
    chk("abort_busy", busy, 1);
    rd0 = rd_cnt;
    tick(5);
    chk("abort_no_rd", rd_cnt, rd0);
    chk("abort_total_hold", total_count, 0);
    send(rom[0][3:0], 3);
    chk("abort_wait_accepts", total_count, 1);
    chk("abort_correct_after", correct_count, m_correct);

    fill_rom();
    pulse_start();
    feed(N, N);
    tick(3);
    chk("mid_divide_not_done", all_done, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("rstdiv_total", total_count, 0);
    chk("rstdiv_correct", correct_count, 0);
    chk("rstdiv_busy", busy, 0);
    chk("rstdiv_done", all_done, 0);
    chk("rstdiv_pct", accuracy_pct, 0);
    rd0 = rd_cnt;
    tick(110);
    chk("rstdiv_stays_idle", all_done, 0);
    send(4'd0, 3);
    chk("idle_ignores_total", total_count, 0);
    chk("idle_no_rd", rd_cnt, rd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
